// File: rtl/mul_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mul_pkg                                                        |
// | Purpose : Shared definitions for the RV32M iterative multiplier and the  |
// |           EX controller: mulctl operation encodings, multiplier state    |
// |           encodings and operand-signedness helpers.                      |
// | Ports   : none (package)                                                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package mul_pkg;

  // mulctl operation encodings (also used by the EX controller)
  localparam logic [1:0] MULCTL_MUL    = 2'b00;
  localparam logic [1:0] MULCTL_MULH   = 2'b01;
  localparam logic [1:0] MULCTL_MULHSU = 2'b10;
  localparam logic [1:0] MULCTL_MULHU  = 2'b11;

  // Multiplier sequencer states
  typedef enum logic [1:0] {
    MU_IDLE = 2'd0,
    MU_CALC = 2'd1,
    MU_FIN  = 2'd2
  } mu_state_t;

  // rs1 is treated as signed for mul, mulh and mulhsu
  function automatic logic rs1_is_signed(input logic [1:0] ctl);
    return (ctl != MULCTL_MULHU);
  endfunction

  // rs2 is treated as signed only for mul and mulh
  function automatic logic rs2_is_signed(input logic [1:0] ctl);
    return (ctl == MULCTL_MUL) || (ctl == MULCTL_MULH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_signfix.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mul_signfix                                                    |
// | Purpose : Combinational conditional two's complement. Used both to take  |
// |           operand magnitudes and to restore the sign of the product.     |
// | Ports   : neg    in  1      negate when high                             |
// |           in_val in  WIDTH  value to condition                           |
// |           out    out WIDTH  neg ? -in_val : in_val                        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mul_signfix #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] in_val,
  output logic [WIDTH-1:0] out
);

  // Unsigned negation: the most negative value maps to itself, which read as
  // an unsigned magnitude is exactly 2^(WIDTH-1).
  assign out = neg ? (~in_val + {{(WIDTH-1){1'b0}}, 1'b1}) : in_val;

endmodule
`default_nettype wire

// File: rtl/mul_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mul_unit                                                       |
// | Purpose : Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) in the EX   |
// |           stage. Magnitude shift-and-add, BITS_PER_CYCLE multiplier bits |
// |           per iteration, sign restored on the full 2*XLEN product.       |
// | Ports   : clk      in  1     rising-edge clock                           |
// |           rst_n    in  1     synchronous active-low reset                |
// |           mulstart in  1     start request (sampled while idle)          |
// |           mulctl   in  2     00 mul, 01 mulh, 10 mulhsu, 11 mulhu        |
// |           flush    in  1     abort in-flight operation                   |
// |           rs1      in  XLEN  multiplicand                                |
// |           rs2      in  XLEN  multiplier                                  |
// |           busy     out 1     operation in flight                         |
// |           done     out 1     one-cycle pulse, result valid               |
// |           result   out XLEN  product slice, held until next start        |
// | Options : MUL_UNIT_EARLY_OUT_EN - zero operand skips the CALC phase      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mul_unit
  import mul_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1    // legal: 1, 2, 4; must divide XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mulstart,
  input  logic [1:0]      mulctl,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int ITER  = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mu_state_t         state;
  logic [1:0]        op;
  logic              prod_neg;
  logic [2*XLEN-1:0] mcand;     // multiplicand magnitude, shifted left per step
  logic [XLEN-1:0]   mplier;    // multiplier magnitude, consumed from the LSB
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  count;

  logic              rs1_neg;
  logic              rs2_neg;
  logic [XLEN-1:0]   rs1_mag;
  logic [XLEN-1:0]   rs2_mag;
  logic [2*XLEN-1:0] partial;
  logic [2*XLEN-1:0] product;

  assign rs1_neg = rs1_is_signed(mulctl) & rs1[XLEN-1];
  assign rs2_neg = rs2_is_signed(mulctl) & rs2[XLEN-1];

  mul_signfix #(.WIDTH(XLEN)) u_mag_rs1 (
    .neg    (rs1_neg),
    .in_val (rs1),
    .out    (rs1_mag)
  );

  mul_signfix #(.WIDTH(XLEN)) u_mag_rs2 (
    .neg    (rs2_neg),
    .in_val (rs2),
    .out    (rs2_mag)
  );

  // Restore the sign of the accumulated magnitude product
  mul_signfix #(.WIDTH(2*XLEN)) u_prod_fix (
    .neg    (prod_neg),
    .in_val (acc),
    .out    (product)
  );

  // Partial product for this step: multiplicand times the low
  // BITS_PER_CYCLE bits of the remaining multiplier.
  always_comb begin
    partial = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      if (mplier[b]) begin
        partial = partial + (mcand << b);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= MU_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      op       <= MULCTL_MUL;
      prod_neg <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MU_IDLE: begin
          // flush has priority over a simultaneous start
          if (mulstart && !flush) begin
            op       <= mulctl;
            prod_neg <= rs1_neg ^ rs2_neg;
            mcand    <= {{XLEN{1'b0}}, rs1_mag};
            mplier   <= rs2_mag;
            acc      <= '0;
            count    <= '0;
            busy     <= 1'b1;
`ifdef MUL_UNIT_EARLY_OUT_EN
            // A zero operand gives a zero product; the cleared accumulator
            // already holds it, so go straight to the result stage.
            if ((rs1 == '0) || (rs2 == '0)) begin
              state <= MU_FIN;
            end else begin
              state <= MU_CALC;
            end
`else
            state <= MU_CALC;
`endif
          end
        end

        MU_CALC: begin
          if (flush) begin
            state <= MU_IDLE;
            busy  <= 1'b0;
          end else begin
            acc    <= acc + partial;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
            count  <= count + CNT_ONE;
            if (count == CNT_LAST) begin
              state <= MU_FIN;
            end
          end
        end

        MU_FIN: begin
          state <= MU_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            result <= (op == MULCTL_MUL) ? product[XLEN-1:0]
                                         : product[2*XLEN-1:XLEN];
            done   <= 1'b1;
          end
        end

        default: begin
          state <= MU_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative RV32M multiplier (MU) in the EX stage, directly downstream of the EX controller.
- Consumes mulstart/mulctl plus the rs1/rs2 operand values and computes MUL, MULH, MULHSU and MULHU.
- Its result feeds the EX result mux on the MU input, selected when ifuresctl = 1.
- Multi-cycle, with a start/done handshake and a busy flag that the hazard logic uses to stall.

Parameters:
- XLEN, 32, operand and result width.
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration. Legal values are 1, 2 and 4; XLEN must be divisible by it.

Ports:
- clk  input  1  Rising-edge clock.
- rst_n  input  1  Synchronous, active-low reset.
- mulstart  input  1  Start request; sampled only while idle.
- mulctl  input  2  Operation: 00 mul, 01 mulh, 10 mulhsu, 11 mulhu.
- flush  input  1  Abort any in-flight operation (pipeline flush).
- rs1  input  XLEN  Multiplicand operand.
- rs2  input  XLEN  Multiplier operand.
- busy  output  1  High while an operation is in flight.
- done  output  1  One-cycle pulse; result is valid in this cycle.
- result  output  XLEN  Product slice. Held stable from done until the next accepted start.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. rst_n=0 at a clock edge forces state IDLE, busy=0, done=0, result=0 and clears the counter and accumulator. This applies even mid-operation.
- Definitions: ITER = XLEN/BITS_PER_CYCLE. Latency LAT = ITER+1.
- States:
  - IDLE: busy=0. If mulstart=1 and flush=0, latch rs1, rs2 and mulctl. Store operand magnitudes and record the sign flags, then go to CALC with counter=0 and accumulator=0.
  - CALC: busy=1. Each cycle, add (multiplicand magnitude × next BITS_PER_CYCLE multiplier bits), shifted into a 2*XLEN accumulator. Counter increments each cycle; after ITER cycles go to FIN.
  - FIN: busy=1. Negate the 2*XLEN product if the sign flags differ, then load result and pulse done. Return to IDLE.
- Operand signedness:
  - mul and mulh: both operands signed.
  - mulhsu: rs1 signed, rs2 unsigned.
  - mulhu: both unsigned.
  - Magnitude of the most negative value is 2^(XLEN-1), held in XLEN unsigned bits.
- Result slice: mul returns product[XLEN-1:0]; all others return product[2*XLEN-1:XLEN].
- Timing: done is high exactly LAT cycles after the cycle in which mulstart was sampled. That is 33 cycles for the defaults. busy falls in the same cycle done rises.
- Back-to-back: mulstart in the done cycle is accepted, since the block is IDLE that cycle.
- mulstart while busy: ignored; operands are not relatched.
- flush: if high in CALC or FIN, return to IDLE next edge with no done pulse; result keeps its previous value. If flush and mulstart are high together in IDLE, flush wins and nothing is started.
- Operand changes after the start cycle have no effect on the operation.

Optional Feature:
- Macro: MUL_UNIT_EARLY_OUT_EN.
- With it defined: if either latched operand is zero at start, skip CALC and go straight to FIN. result=0 and done arrives 1 cycle after start.
- Without it: all operations take LAT cycles.

Decomposition:
- Shared package mul_pkg holds:
  - mulctl encodings MULCTL_MUL=2'b00, MULCTL_MULH=2'b01, MULCTL_MULHSU=2'b10, MULCTL_MULHU=2'b11;
  - state encodings MU_IDLE, MU_CALC, MU_FIN.
- The EX controller imports the same mulctl constants.
- One sub-module: mul_signfix, a combinational conditional two's-complement of parameterised width. It is used for operand magnitudes (XLEN) and for the product fixup (2*XLEN).

Test Plan:
- mul: rs1=7, rs2=0xFFFFFFFD (−3), pulse start -> done exactly 33 cycles later with result=0xFFFFFFEB; busy high for 33 cycles.
- mulh: 0x80000000 × 0x80000000 -> result=0x40000000.
- mulhsu: 0xFFFFFFFF × 0xFFFFFFFF -> result=0xFFFFFFFF. mulhu with the same operands -> result=0xFFFFFFFE.
- Busy and back-to-back: pulse start at cycle 5 of a running op with other operands -> ignored, original result returned. A new start in the done cycle -> second result 33 cycles later.
- flush at cycle 10 of CALC -> no done pulse, busy=0 next cycle, result unchanged. rst_n=0 at cycle 12 of another op -> busy=0, done=0, result=0 after that edge.
- With MUL_UNIT_EARLY_OUT_EN: mul 0 × 0x1234 -> done 1 cycle after start, result=0. Without the macro -> done at 33 cycles, result=0.
